// File: rtl/tim_pkg.sv
// Shared types for the tightly-integrated-memory requester: word geometry and
// the response record carried through the response queue.
package tim_pkg;

  localparam int TIM_WORD_W = 32;
  localparam int TIM_LANES  = 4;

  typedef struct packed {
    logic                  write;
    logic [TIM_WORD_W-1:0] data;
  } tim_rsp_t;

  // Writes return zero data; the array output is meaningless after a write.
  function automatic logic [TIM_WORD_W-1:0] tim_rsp_data(
    input logic                  write,
    input logic [TIM_WORD_W-1:0] rdata
  );
    return write ? {TIM_WORD_W{1'b0}} : rdata;
  endfunction

endpackage

// File: rtl/tim_rsp_fifo.sv
// Flow-through response FIFO: when empty, an incoming entry is visible on the
// output in the same cycle and bypasses storage if consumed immediately.
module tim_rsp_fifo
  import tim_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enq_valid,
  input  tim_rsp_t         enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output tim_rsp_t         deq_data,
  output logic [CNT_W-1:0] occ
);

  tim_rsp_t         mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] occ_r;
  logic             empty_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Handshake decode and output selection between head entry and bypass.
  always_comb begin
    empty_s   = (occ_r == {CNT_W{1'b0}});
    bypass_s  = empty_s & enq_valid & deq_ready;
    push_s    = enq_valid & ~bypass_s;
    pop_s     = ~empty_s & deq_ready;
    deq_valid = ~empty_s | enq_valid;
    if (empty_s) begin
      deq_data = enq_data;
    end else begin
      deq_data = mem_r[rd_ptr_r];
    end
    occ = occ_r;
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{write: 1'b0, data: {TIM_WORD_W{1'b0}}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= enq_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + CNT_W'(1);
        2'b01:   occ_r <= occ_r - CNT_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: rtl/tim_array_requester.sv
// Initiator-side controller for the TIM data array: maps accepted requests onto
// the array port and returns one in-order response per request.
module tim_array_requester
  import tim_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int RSP_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [TIM_LANES-1:0]  req_mask,
  input  logic [TIM_WORD_W-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [TIM_WORD_W-1:0] rsp_data,
  output logic                  arr_en,
  output logic                  arr_wen,
  output logic [ADDR_W-3:0]     arr_addr,
  output logic [TIM_LANES-1:0]  arr_mask,
  output logic [TIM_WORD_W-1:0] arr_wdata,
  input  logic [TIM_WORD_W-1:0] arr_rdata
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic             inflight_r;
  logic             inflight_write_r;
  logic [CNT_W-1:0] occ_s;
  logic [CNT_W:0]   pending_s;
  logic             fire_s;
  tim_rsp_t         stage_s;
  tim_rsp_t         head_s;

  // Accept and array mapping; ready depends on registered state only, so every
  // accepted request is guaranteed a queue slot.
  always_comb begin
    pending_s = {1'b0, occ_s} + {{CNT_W{1'b0}}, inflight_r};
    req_ready = (pending_s < (CNT_W + 1)'(RSP_DEPTH));
    fire_s    = req_valid & req_ready & reset_n;
    arr_en    = fire_s;
    arr_wen   = fire_s & req_write;
    arr_addr  = req_addr[ADDR_W-1:2];
    arr_mask  = req_mask;
    arr_wdata = req_data;
    stage_s   = '{write: inflight_write_r,
                  data:  tim_rsp_data(inflight_write_r, arr_rdata)};
    rsp_write = head_s.write;
    rsp_data  = head_s.data;
  end

  // In-flight stage: marks the cycle in which array read data is valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_r       <= 1'b0;
      inflight_write_r <= 1'b0;
    end else begin
      inflight_r       <= fire_s;
      inflight_write_r <= req_write;
    end
  end

  tim_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .enq_valid (inflight_r),
    .enq_data  (stage_s),
    .deq_valid (rsp_valid),
    .deq_ready (rsp_ready),
    .deq_data  (head_s),
    .occ       (occ_s)
  );

endmodule

// File: tb/tb_tim_array_requester.sv
// Scoreboard bench for tim_array_requester with a behavioural single-port array.
module tb_tim_array_requester;

  localparam int ADDR_W = 14;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [13:0] req_addr = 14'h0;
  logic [3:0]  req_mask = 4'h0;
  logic [31:0] req_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_write;
  logic [31:0] rsp_data;
  logic        arr_en;
  logic        arr_wen;
  logic [11:0] arr_addr;
  logic [3:0]  arr_mask;
  logic [31:0] arr_wdata;
  logic [31:0] arr_rdata = 32'hBAD0_BAD0;

  typedef struct {
    logic        write;
    logic [31:0] data;
    int          acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [4096];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_acc = 0;
  int          cyc_cnt = 0;
  bit          check_lat = 1'b0;

  tim_array_requester #(.ADDR_W(ADDR_W), .RSP_DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .arr_en(arr_en), .arr_wen(arr_wen),
    .arr_addr(arr_addr), .arr_mask(arr_mask), .arr_wdata(arr_wdata),
    .arr_rdata(arr_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // Behavioural array: 1-cycle read latency, garbage on rdata otherwise.
  always @(posedge clock) begin
    if (arr_en && arr_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (arr_mask[i]) mem[arr_addr][8*i +: 8] <= arr_wdata[8*i +: 8];
      end
      arr_rdata <= 32'hBAD0_BAD0;
    end else if (arr_en) begin
      arr_rdata <= mem[arr_addr];
    end else begin
      arr_rdata <= 32'hBAD0_BAD0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: pop and compare on every response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rsp: got write=%0b data=0x%08h expected no response",
                   rsp_write, rsp_data);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_write", {31'h0, rsp_write}, {31'h0, e.write});
          chk("rsp_data", rsp_data, e.data);
          if (check_lat) chk("rsp_latency", 32'(cyc_cnt - e.acc_cyc), 32'd1);
        end
      end
    end
  end

  // Issue one request; waits (bounded) for acceptance and pushes the expectation.
  task automatic issue(input logic wr, input logic [13:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic [31:0] exp_data,
                       input bit no_stall);
    int   waited = 0;
    exp_t e;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_mask  = mask;
    req_data  = data;
    @(negedge clock);
    while (!req_ready && waited < 200) begin
      waited++;
      @(negedge clock);
    end
    if (!req_ready) begin
      n_chk++;
      $display("FAIL accept_timeout: got req_ready=0 expected acceptance within 200 cycles");
    end else begin
      chk("arr_en", {31'h0, arr_en}, 32'h1);
      chk("arr_wen", {31'h0, arr_wen}, {31'h0, wr});
      chk("arr_addr", {20'h0, arr_addr}, {20'h0, addr[13:2]});
      chk("arr_mask", {28'h0, arr_mask}, {28'h0, mask});
      chk("arr_wdata", arr_wdata, data);
      if (no_stall) chk("no_stall_wait", 32'(waited), 32'd0);
      e.write   = wr;
      e.data    = exp_data;
      e.acc_cyc = cyc_cnt;
      sb_q.push_back(e);
      n_acc++;
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

    // Reset: array stays disabled even with a pending request.
    req_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_arr_en", {31'h0, arr_en}, 32'h0);
    req_valid = 1'b0;
    reset_n   = 1'b1;
    @(posedge clock);
    #1;
    chk("idle_arr_en", {31'h0, arr_en}, 32'h0);

    // Full-word write then read back; word index 0x004.
    check_lat = 1'b1;
    issue(1'b1, 14'h0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue(1'b0, 14'h0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    drain();

    // Byte-lane merge.
    issue(1'b1, 14'h0020, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
    issue(1'b1, 14'h0020, 4'h2, 32'h0000_AB00, 32'h0, 1'b0);
    issue(1'b0, 14'h0020, 4'h0, 32'h0, 32'h1122_AB44, 1'b0);
    drain();

    // Back-to-back writes then reads, one per cycle.
    for (int i = 0; i < 8; i++)
      issue(1'b1, 14'(14'h0040 + 4 * i), 4'hF, 32'hA5A5_0000 | 32'(i), 32'h0, 1'b1);
    for (int i = 0; i < 8; i++)
      issue(1'b0, 14'(14'h0040 + 4 * i), 4'h0, 32'h0, 32'hA5A5_0000 | 32'(i), 1'b1);
    drain();

    // Stall: only two reads accepted while rsp_ready is low.
    check_lat = 1'b0;
    rsp_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++)
          issue(1'b0, 14'(14'h0040 + 4 * i), 4'h0, 32'h0, 32'hA5A5_0000 | 32'(i), 1'b0);
      end
      begin
        repeat (6) @(negedge clock);
        chk("stall_accepted", 32'(n_acc - base), 32'd2);
        chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
        chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("stall_rsp_data", rsp_data, 32'hA5A5_0000);
        repeat (2) @(negedge clock);
        chk("stall_rsp_data_hold", rsp_data, 32'hA5A5_0000);
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset with two responses queued drops them.
    rsp_ready = 1'b0;
    issue(1'b0, 14'h0040, 4'h0, 32'h0, 32'hA5A5_0000, 1'b0);
    issue(1'b0, 14'h0044, 4'h0, 32'h0, 32'hA5A5_0001, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    chk("queued_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    reset_n   = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    #1;
    chk("midreset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("midreset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("midreset_arr_en", {31'h0, arr_en}, 32'h0);
    sb_q.delete();
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    check_lat = 1'b1;
    issue(1'b0, 14'h0020, 4'h0, 32'h0, 32'h1122_AB44, 1'b0);
    drain();

    // Mask-zero write: array enabled, contents untouched, response produced.
    issue(1'b1, 14'h0010, 4'h0, 32'h1234_5678, 32'h0, 1'b0);
    issue(1'b0, 14'h0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tim_array_requester.md
Name: tim_array_requester

Overview:
- Initiator-side controller that drives the tightly-integrated-memory data array wrapper: one 32-bit word, 4 byte lanes, 4096 words, synchronous single-port SRAM with 1-cycle read latency.
- Accepts word requests on a valid/ready channel and converts them to array enable, write-enable, byte-mask, index and data.
- Captures read data the cycle after the access and returns one in-order response per request through a flow-through response queue.
- Sits between the core load/store/fetch port and the data array.

Parameters:
- ADDR_W, 14, byte-address width; word index = req_addr[ADDR_W-1:2].
- RSP_DEPTH, 2, response queue entries (minimum 2; full throughput at 2).

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- req_mask  in  4  byte-lane write enables, bit i covers data[8i+7:8i].
- req_data  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_write  out  1  response belongs to a write.
- rsp_data  out  32  read data; 0 for writes.
- arr_en  out  1  array chip enable.
- arr_wen  out  1  array write enable.
- arr_addr  out  ADDR_W-2  array word index.
- arr_mask  out  4  array byte mask.
- arr_wdata  out  32  array write data.
- arr_rdata  in  32  array read data, valid only in the cycle after a read enable.

Behaviour:
- Reset (async assert, sync deassert): queue empty, in-flight flag clear.
  - Resulting outputs: rsp_valid=0, req_ready=1, arr_en=0.
  - A reset mid-transaction drops in-flight and queued responses; no array access is issued while reset_n=0.
- Accept: fire = req_valid & req_ready.
  - arr_en=fire.
  - arr_wen=fire&req_write.
  - arr_addr=req_addr[ADDR_W-1:2], arr_mask=req_mask, arr_wdata=req_data, combinational pass-through.
- Write with req_mask=0: the array is still enabled with mask 0 and a response is still produced.
- In-flight stage: register inflight<=fire and inflight_write<=req_write.
  - In the next cycle the stage result is {write, write ? 0 : arr_rdata}.
- Flow-through queue, RSP_DEPTH entries:
  - Queue empty and inflight=1: the result drives rsp_valid/rsp_data directly in that cycle. If rsp_ready=1 it is consumed without enqueue; otherwise it is enqueued.
  - Queue non-empty: head drives the outputs and the in-flight result is enqueued at the tail.
  - Responses are strictly in request order.
- Flow control: req_ready = (occ + inflight) < RSP_DEPTH.
  - Computed from registers only; no combinational path from rsp_ready or req_valid.
  - This guarantees a slot exists for every accepted request; overflow is impossible.
  - Simultaneous enqueue and dequeue leave the occupancy count unchanged.
- Throughput and latency: with rsp_ready held at 1, one request per cycle; response latency is exactly 1 cycle (accept in cycle N, rsp_valid in N+1).
- Stall: with rsp_ready=0, at most RSP_DEPTH requests are accepted, then req_ready=0 until a dequeue.
- rsp_valid, once asserted, stays asserted with stable data until consumed (queued entries hold; the flow-through result is enqueued if not consumed).
- Pointers wrap modulo RSP_DEPTH; the count width is clog2(RSP_DEPTH+1).

Decomposition:
- Shared package tim_pkg:
  - TIM_WORD_W=32, TIM_LANES=4.
  - Response struct {logic write; logic [31:0] data}.
- One sub-module, tim_rsp_fifo: a parameterised flow-through FIFO with enq/deq handshakes and an occ output.
- The top level holds accept logic, the in-flight register, and array signal mapping.

Test Plan:
- Reset then write 0xDEADBEEF to addr 0x0010, mask 0xF, then read 0x0010 → arr_addr=0x004; write response rsp_write=1, data 0; read response data 0xDEADBEEF one cycle after accept.
- Byte-lane write mask 0x2 with data 0x0000AB00 to a word holding 0x11223344, then read → 0x1122AB44.
- Back-to-back reads of 8 consecutive words with rsp_ready=1 → req_ready never drops, one response per cycle, in order.
- rsp_ready=0 while issuing 4 reads → exactly 2 accepted, req_ready=0, rsp_valid stable with the first read data; release rsp_ready → both drain in order, then the remaining 2 are accepted.
- Assert reset_n=0 with 2 responses queued → rsp_valid=0, req_ready=1 immediately, arr_en=0; after release a new read returns correct data with no stale response.
- Write with mask 0x0 → arr_en=1, arr_mask=0, stored data unchanged on readback, one write response produced.
